// File: rtl/seg_scan_ctrl_if.sv
// Display-data load channel for seg_scan_ctrl: valid/ready transfer of one
// nibble per digit, nibble i at bits [4i+3:4i].
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                wr_valid;
  logic [4*DIGITS-1:0] wr_data;
  logic                wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller.
// Each digit slot is a dark BLANK phase followed by a SHOW phase. num is
// updated only at slot start so the shared decoder settles while digits are
// dark. New data is staged in a pending register and committed only at a
// frame boundary so a frame never mixes old and new digits.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_ctrl_if.slave    wr,
  input  logic              lz_en,
  output logic [3:0]        num,
  output logic [DIGITS-1:0] dig_en,
  output logic              frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int DAT_W = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [3:0]          num_r, num_s;
  logic [DIGITS-1:0]   dig_en_r, dig_en_s;
  logic                tick_r, tick_s;
  logic [DAT_W-1:0]    disp_r;
  logic [DAT_W-1:0]    pend_r;
  logic                pend_flag_r, pend_flag_s;
  logic                wr_ready_r, wr_ready_s;
  logic                xfer_s;
  logic                slot_end_s;
  logic                blank_end_s;
  logic                wrap_s;
  logic                commit_s;
  logic [DAT_W-1:0]    commit_data_s;

  // Nibble of digit i from a packed display word.
  function automatic logic [3:0] nib_f(input logic [DAT_W-1:0] d,
                                       input logic [IDX_W-1:0] i);
    logic [3:0] r;
    r = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      r = (i == IDX_W'(k)) ? d[4*k +: 4] : r;
    end
    return r;
  endfunction

  // One-hot digit enable for digit i.
  function automatic logic [DIGITS-1:0] onehot_f(input logic [IDX_W-1:0] i);
    logic [DIGITS-1:0] r;
    r = {DIGITS{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      r[k] = (i == IDX_W'(k));
    end
    return r;
  endfunction

  // True when digit i is a leading zero that should stay dark: i>0 and all
  // nibbles from the top digit down to i are zero.
  function automatic logic lz_blank_f(input logic [DAT_W-1:0] d,
                                      input logic [IDX_W-1:0] i,
                                      input logic             en);
    logic r;
    r = en & (i != IDX_ZERO);
    for (int k = 0; k < DIGITS; k++) begin
      r = r & ~((IDX_W'(k) >= i) & (d[4*k +: 4] != 4'h0));
    end
    return r;
  endfunction

  // Handshake bookkeeping; a word written on the wrap cycle itself still
  // makes the coming frame boundary.
  always_comb begin
    xfer_s        = wr.wr_valid & wr_ready_r;
    slot_end_s    = (cnt_r == CNT_LAST);
    blank_end_s   = (cnt_r == BLANK_LAST);
    wrap_s        = slot_end_s & (idx_r == IDX_LAST);
    commit_s      = wrap_s & (pend_flag_r | xfer_s);
    commit_data_s = xfer_s ? wr.wr_data : pend_r;
    if (commit_s) begin
      pend_flag_s = 1'b0;
    end else if (xfer_s) begin
      pend_flag_s = 1'b1;
    end else begin
      pend_flag_s = pend_flag_r;
    end
    wr_ready_s = ~pend_flag_s & ~commit_s;
  end

  // Scan FSM next state and next registered output values.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    num_s    = num_r;
    dig_en_s = dig_en_r;
    tick_s   = 1'b0;
    cnt_s    = slot_end_s ? CNT_ZERO : (cnt_r + CNT_ONE);
    case (state_r)
      ST_BLANK: begin
        if (blank_end_s) begin
          state_s  = ST_SHOW;
          dig_en_s = lz_blank_f(disp_r, idx_r, lz_en) ? {DIGITS{1'b0}}
                                                      : onehot_f(idx_r);
        end else begin
          dig_en_s = {DIGITS{1'b0}};
        end
      end
      ST_SHOW: begin
        if (slot_end_s) begin
          state_s  = ST_BLANK;
          dig_en_s = {DIGITS{1'b0}};
          idx_s    = wrap_s ? IDX_ZERO : (idx_r + IDX_ONE);
          tick_s   = wrap_s;
          num_s    = commit_s ? commit_data_s[3:0] : nib_f(disp_r, idx_s);
        end else begin
          dig_en_s = dig_en_r;
        end
      end
      default: begin
        state_s  = ST_BLANK;
        dig_en_s = {DIGITS{1'b0}};
      end
    endcase
  end

  // Scan state register: FSM state, slot counter, digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_BLANK;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_r    <= 4'h0;
      dig_en_r <= {DIGITS{1'b0}};
      tick_r   <= 1'b0;
    end else begin
      num_r    <= num_s;
      dig_en_r <= dig_en_s;
      tick_r   <= tick_s;
    end
  end

  // Pending/display data registers and the ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_r      <= {DAT_W{1'b0}};
      pend_r      <= {DAT_W{1'b0}};
      pend_flag_r <= 1'b0;
      wr_ready_r  <= 1'b1;
    end else begin
      if (commit_s) begin
        disp_r <= commit_data_s;
      end else begin
        disp_r <= disp_r;
      end
      if (xfer_s) begin
        pend_r <= wr.wr_data;
      end else begin
        pend_r <= pend_r;
      end
      pend_flag_r <= pend_flag_s;
      wr_ready_r  <= wr_ready_s;
    end
  end

  assign num         = num_r;
  assign dig_en      = dig_en_r;
  assign frame_tick  = tick_r;
  assign wr.wr_ready = wr_ready_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl. The driver advances a cycle-indexed
// reference model (slot/phase derived arithmetically from the cycle number
// since reset) and queues the expected outputs; a negedge monitor compares.
module tb_seg_scan_ctrl;

  localparam int D  = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int F  = D * SD;

  typedef struct packed {
    logic [3:0]   num;
    logic [D-1:0] dig;
    logic         tick;
    logic         ready;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         lz_en;
  logic [3:0]   num;
  logic [D-1:0] dig_en;
  logic         frame_tick;

  seg_scan_ctrl_if #(.DIGITS(D)) wr_if ();

  seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr_if),
    .lz_en      (lz_en),
    .num        (num),
    .dig_en     (dig_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // reference model state (describes the current cycle)
  bit              m_valid = 1'b0;
  int              m_t     = 0;
  logic [4*D-1:0]  m_disp  = '0;
  logic [4*D-1:0]  m_pend  = '0;
  bit              m_pflag = 1'b0;
  bit              m_ready = 1'b1;
  bit              m_lz    = 1'b0;

  function automatic exp_t model_out();
    exp_t e;
    int ph  = m_t % SD;
    int idx = (m_t / SD) % D;
    logic [4*D-1:0] upper;
    e.num   = m_disp[4*idx +: 4];
    e.ready = m_ready;
    e.tick  = (m_t > 0) && (m_t % F == 0);
    upper   = m_disp >> (4 * idx);
    if (ph < BC)
      e.dig = '0;
    else if (m_lz && idx > 0 && upper == '0)
      e.dig = '0;
    else
      e.dig = D'(1) << idx;
    return e;
  endfunction

  // one clock: queue expectation for this cycle, then advance the model
  task automatic cycle();
    bit xfer;
    bit commit;
    if (m_valid) exp_q.push_back(model_out());
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b1;
      m_t     = 0;
      m_disp  = '0;
      m_pend  = '0;
      m_pflag = 1'b0;
      m_ready = 1'b1;
    end else if (m_valid) begin
      xfer = wr_if.wr_valid && m_ready;
      if (xfer) begin
        m_pend  = wr_if.wr_data;
        m_pflag = 1'b1;
      end
      if (m_t % SD == BC - 1) m_lz = lz_en;
      commit = ((m_t + 1) % F == 0) && m_pflag;
      if (commit) begin
        m_disp  = m_pend;
        m_pflag = 1'b0;
      end
      m_ready = !m_pflag && !commit;
      m_t++;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to_phase(input int p);
    int guard = 0;
    while ((m_t % F) != p && guard < 2 * F) begin
      cycle();
      guard++;
    end
  endtask

  // offer data and hold it until the transfer cycle
  task automatic do_write(input logic [4*D-1:0] d, input int max_wait);
    int  w = 0;
    bit  acc;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    forever begin
      acc = m_ready;
      cycle();
      if (acc) break;
      w++;
      if (w > max_wait) begin
        n_cmp++;
        n_fail++;
        $display("FAIL write_accept: data %h not accepted after %0d cycles, required within %0d", d, w, max_wait);
        break;
      end
    end
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  // monitor: compare DUT outputs to the queued expectation each cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (num !== e.num || dig_en !== e.dig || frame_tick !== e.tick ||
          wr_if.wr_ready !== e.ready) begin
        n_fail++;
        $display("FAIL scan_out t=%0d: num/dig_en/tick/ready got %h/%b/%b/%b required %h/%b/%b/%b",
                 m_t, num, dig_en, frame_tick, wr_if.wr_ready,
                 e.num, e.dig, e.tick, e.ready);
      end
    end
  end

  initial begin
    logic [4*D-1:0] mask;
    rst            = 1'b1;
    lz_en          = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    run(3);
    rst = 1'b0;

    // idle scan after reset, two frames plus
    run(70);

    // single write mid-frame, then observe a full frame of 0x1234
    run_to_phase(12);
    do_write(16'h1234, 4 * F);
    run(2 * F);

    // back-to-back: second word held while the first is pending
    run_to_phase(5);
    do_write(16'h1234, 4 * F);
    do_write(16'h9999, 4 * F);
    run(2 * F + 4);

    // leading-zero blanking
    lz_en = 1'b1;
    do_write(16'h0045, 4 * F);
    run(2 * F + 4);

    // all-zero display with blanking: only digit 0 lights
    do_write(16'h0000, 4 * F);
    run(2 * F + 4);

    // reset during SHOW of digit 2 with a write pending
    run_to_phase(1);
    do_write(16'h7777, 4 * F);
    run_to_phase(2 * SD + 4);
    do_reset(1);
    run(F + 8);

    // dash in top digit, nothing blanked
    do_write(16'hA000, 4 * F);
    run(2 * F + 4);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      int gap = $urandom_range(0, 40);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
        cycle();
      end
      case ($urandom_range(0, 3))
        0:       mask = 16'h000F;
        1:       mask = 16'h00FF;
        2:       mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      if ($urandom_range(0, 40) == 0) begin
        do_reset($urandom_range(1, 3));
      end
      do_write(16'($urandom) & mask, 4 * F);
    end
    run(2 * F);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
